// File: rtl/btn_pkg.sv
// Shared constants, FSM encoding and counter-width helper for the button debouncer.
package btn_pkg;

  localparam int N_BTN_DEF     = 5;
  localparam int STABLE_MS_DEF = 20;

  localparam logic [0:0] ST_STABLE   = 1'b0;
  localparam logic [0:0] ST_CHANGING = 1'b1;

  // ceil(log2(stable_ms+1)), never less than 1
  function automatic int cnt_w_for(input int stable_ms);
    int w;
    w = 1;
    while ((1 << w) < stable_ms + 1) w++;
    return w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: 2-flop synchroniser, ms-tick counter, two-state FSM and
// registered press/release pulses.
module debounce_channel
  import btn_pkg::*;
#(
  parameter int STABLE_MS = STABLE_MS_DEF,
  parameter int CNT_W     = cnt_w_for(STABLE_MS_DEF)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_MS - 1);

  logic [1:0]       sync;
  logic             btn_s;
  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_cur;

  assign btn_s   = sync[1];
  // the counter is only meaningful while a change is pending
  assign cnt_cur = (state == ST_STABLE) ? '0 : cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync        <= '0;
      state       <= ST_STABLE;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      sync        <= {sync[0], btn_raw};
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      if (btn_s == btn_level) begin
        // a return to the current level aborts any pending change
        state <= ST_STABLE;
        cnt   <= '0;
      end else if (tick) begin
        if (cnt_cur == CNT_LAST) begin
          state       <= ST_STABLE;
          cnt         <= '0;
          btn_level   <= btn_s;
          btn_press   <= btn_s;
          btn_release <= ~btn_s;
        end else begin
          state <= ST_CHANGING;
          cnt   <= cnt_cur + CNT_W'(1);
        end
      end else begin
        state <= ST_CHANGING;
        cnt   <= cnt_cur;
      end
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// N_BTN-channel push-button debouncer; the 1 kHz ms_clk is sampled as data and its
// rising edge becomes a one-clk tick shared by all channels.
module button_debouncer
  import btn_pkg::*;
#(
  parameter int N_BTN     = N_BTN_DEF,
  parameter int STABLE_MS = STABLE_MS_DEF,
  parameter int CNT_W     = cnt_w_for(STABLE_MS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ms_clk,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  logic ms_d;
  logic tick;

  // ms_d resets high so a high ms_clk at reset release is not seen as an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ms_d <= 1'b1;
    else        ms_d <= ms_clk;
  end

  assign tick = ms_clk & ~ms_d;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    debounce_channel #(
      .STABLE_MS(STABLE_MS),
      .CNT_W    (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .btn_raw    (btn_raw[g]),
      .btn_level  (btn_level[g]),
      .btn_press  (btn_press[g]),
      .btn_release(btn_release[g])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: STABLE_MS=4 and STABLE_MS=1 instances share stimulus,
// a cycle scoreboard plus a vector table and directed multi-cycle sequences.
module tb_button_debouncer;

  localparam int NB = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ms_clk = 1'b0;
  logic [NB-1:0] btn_raw = '0;
  logic [NB-1:0] lvl4, prs4, rel4, lvl1, prs1, rel1;

  always #5 clk = ~clk;

  button_debouncer #(.N_BTN(NB), .STABLE_MS(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .ms_clk(ms_clk), .btn_raw(btn_raw),
    .btn_level(lvl4), .btn_press(prs4), .btn_release(rel4)
  );

  button_debouncer #(.N_BTN(NB), .STABLE_MS(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ms_clk(ms_clk), .btn_raw(btn_raw),
    .btn_level(lvl1), .btn_press(prs1), .btn_release(rel1)
  );

  int checks = 0, failures = 0, cyc_n = 0;
  bit ms_run = 1'b1;
  bit rst_v  = 1'b0;
  int ms_cnt = 0;

  typedef struct packed {
    logic [NB-1:0] l4, p4, r4, l1, p1, r1;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [NB-1:0] raw;
    int            n;
    logic [NB-1:0] lvl;
    int            pb, rb, pc;
  } vec_t;

  // reference model: two sync stages, level, and ticks seen while input differs
  logic [NB-1:0] m_s1[2], m_s2[2], m_lvl[2];
  int            m_ticks[2][NB];
  logic          m_msd;

  int r_pb, r_rb, r_pc, r_first, r_p1, r_r1, r_first1;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc_n, act, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_s1[k] = '0; m_s2[k] = '0; m_lvl[k] = '0;
      for (int c = 0; c < NB; c++) m_ticks[k][c] = 0;
    end
    m_msd = 1'b1;
  endtask

  task automatic model_step(output exp_t e);
    logic          tk;
    logic [NB-1:0] p[2], r[2];
    int            sms;
    e = '0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tk    = ms_clk & ~m_msd;
    m_msd = ms_clk;
    for (int k = 0; k < 2; k++) begin
      sms  = (k == 0) ? 4 : 1;
      p[k] = '0; r[k] = '0;
      for (int c = 0; c < NB; c++) begin
        if (m_s2[k][c] != m_lvl[k][c]) begin
          if (tk) m_ticks[k][c]++;
          if (m_ticks[k][c] == sms) begin
            m_lvl[k][c]   = m_s2[k][c];
            p[k][c]       = m_s2[k][c];
            r[k][c]       = ~m_s2[k][c];
            m_ticks[k][c] = 0;
          end
        end else begin
          m_ticks[k][c] = 0;
        end
      end
      m_s2[k] = m_s1[k];
      m_s1[k] = btn_raw;
    end
    e.l4 = m_lvl[0]; e.p4 = p[0]; e.r4 = r[0];
    e.l1 = m_lvl[1]; e.p1 = p[1]; e.r1 = r[1];
  endtask

  // one clk: score last edge's outputs, then drive inputs and predict the next edge
  task automatic cyc(input logic [NB-1:0] raw);
    exp_t e;
    @(negedge clk);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      checks++;
      if ({lvl4, prs4, rel4} !== {e.l4, e.p4, e.r4}) begin
        failures++;
        $display("FAIL sb_ms4 cyc=%0d lvl/prs/rel actual=%b/%b/%b expected=%b/%b/%b",
                 cyc_n, lvl4, prs4, rel4, e.l4, e.p4, e.r4);
      end
      checks++;
      if ({lvl1, prs1, rel1} !== {e.l1, e.p1, e.r1}) begin
        failures++;
        $display("FAIL sb_ms1 cyc=%0d lvl/prs/rel actual=%b/%b/%b expected=%b/%b/%b",
                 cyc_n, lvl1, prs1, rel1, e.l1, e.p1, e.r1);
      end
    end
    rst_n   = rst_v;
    btn_raw = raw;
    if (ms_run) begin
      ms_cnt = (ms_cnt + 1) % 100;
      ms_clk = (ms_cnt >= 50);
    end else begin
      ms_cnt = 0;
      ms_clk = 1'b0;
    end
    model_step(e);
    sbq.push_back(e);
    cyc_n++;
  endtask

  task automatic run(input logic [NB-1:0] raw, input int n);
    r_pb = 0; r_rb = 0; r_pc = 0; r_first = -1;
    r_p1 = 0; r_r1 = 0; r_first1 = -1;
    for (int j = 0; j < n; j++) begin
      cyc(raw);
      if (prs4 != '0) r_pc++;
      r_pb += $countones(prs4);
      r_rb += $countones(rel4);
      if (r_first < 0 && (prs4 | rel4) != '0) r_first = j;
      r_p1 += $countones(prs1);
      r_r1 += $countones(rel1);
      if (r_first1 < 0 && (prs1 | rel1) != '0) r_first1 = j;
    end
  endtask

  initial begin
    vec_t tbl[7];
    int   bp, br, found;
    logic [NB-1:0] rv;

    tbl[0] = '{raw: 5'b00001, n: 500, lvl: 5'b00001, pb: 1, rb: 0, pc: 1};
    tbl[1] = '{raw: 5'b00000, n: 500, lvl: 5'b00000, pb: 0, rb: 1, pc: 0};
    tbl[2] = '{raw: 5'b11111, n: 500, lvl: 5'b11111, pb: 5, rb: 0, pc: 1};
    tbl[3] = '{raw: 5'b00000, n: 500, lvl: 5'b00000, pb: 0, rb: 5, pc: 0};
    tbl[4] = '{raw: 5'b01010, n: 500, lvl: 5'b01010, pb: 2, rb: 0, pc: 1};
    tbl[5] = '{raw: 5'b10101, n: 500, lvl: 5'b10101, pb: 3, rb: 2, pc: 1};
    tbl[6] = '{raw: 5'b00000, n: 500, lvl: 5'b00000, pb: 0, rb: 3, pc: 0};

    model_reset();
    rst_v = 1'b0;
    run('0, 5);
    chk("reset_level", int'(lvl4), 0);
    chk("reset_pulses", int'(prs4 | rel4 | prs1 | rel1), 0);
    rst_v = 1'b1;
    run('0, 1000);
    chk("idle_pulses", r_pb + r_rb + r_p1 + r_r1, 0);
    chk("idle_level", int'(lvl4 | lvl1), 0);

    // reset asserted and released while ms_clk is high: no tick at release
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      cyc('0);
      if (ms_cnt == 50) found = 1;
    end
    chk("ms_high_found", found, 1);
    rst_v = 1'b0;
    run('0, 3);
    rst_v = 1'b1;
    cyc('0);
    chk("no_tick_on_release", int'(ms_clk & dut.tick), 0);
    cyc('0);
    chk("no_tick_after_release", int'(dut.tick), 0);

    for (int i = 0; i < 7; i++) begin
      run(tbl[i].raw, tbl[i].n);
      chk($sformatf("vec%0d_level", i), int'(lvl4), int'(tbl[i].lvl));
      chk($sformatf("vec%0d_press_bits", i), r_pb, tbl[i].pb);
      chk($sformatf("vec%0d_release_bits", i), r_rb, tbl[i].rb);
      chk($sformatf("vec%0d_press_cycles", i), r_pc, tbl[i].pc);
      chk($sformatf("vec%0d_latency_ok", i), int'(r_first >= 303 && r_first <= 403), 1);
    end

    // bounce on bit 1, then settle high
    bp = 0; br = 0;
    for (int s = 0; s < 10; s++) begin
      run((s % 2 == 0) ? 5'b00010 : 5'b00000, 30);
      bp += r_pb; br += r_rb;
    end
    chk("bounce_pulses", bp + br, 0);
    run(5'b00010, 500);
    chk("bounce_settle_press", r_pb, 1);
    chk("bounce_settle_level", int'(lvl4), 2);
    run('0, 500);

    // short glitch on bit 2 never commits
    run(5'b00100, 250);
    bp = r_pb + r_rb;
    run('0, 300);
    chk("glitch_pulses", bp + r_pb + r_rb, 0);
    chk("glitch_level", int'(lvl4), 0);
    chk("glitch_cnt_clear", int'(dut.g_ch[2].u_ch.cnt), 0);

    // reset mid-count with all buttons held
    run(5'b11111, 250);
    chk("midcount_no_press", r_pb, 0);
    rst_v = 1'b0;
    run(5'b11111, 5);
    rst_v = 1'b1;
    run(5'b11111, 300);
    chk("post_reset_early", r_pb, 0);
    run(5'b11111, 200);
    chk("post_reset_press_bits", r_pb, 5);
    chk("post_reset_press_cycles", r_pc, 1);
    chk("post_reset_level", int'(lvl4), 31);

    // ms_clk frozen: no level may change on either instance
    ms_run = 1'b0;
    bp = 0;
    for (int s = 0; s < 27; s++) begin
      rv = NB'($urandom);
      run(rv, 37);
      bp += r_pb + r_rb + r_p1 + r_r1;
    end
    chk("freeze_pulses", bp, 0);
    chk("freeze_level4", int'(lvl4), 31);
    chk("freeze_level1", int'(lvl1), 31);
    ms_run = 1'b1;
    run('0, 110);
    chk("ms1_first_tick_commit", r_first1, 50);
    chk("ms1_release_bits", r_r1, 5);
    chk("ms1_level", int'(lvl1), 0);
    chk("ms4_not_yet", int'(lvl4), 31);
    run('0, 500);
    chk("final_level4", int'(lvl4), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Consumes the 1 kHz square wave `div_clk` from the clock divider, fed in on `ms_clk`.
- Debounces N_BTN raw board push-buttons and outputs a clean per-button level plus one-cycle press and release pulses, all synchronous to the 100 MHz `clk`.
- Sits between the board pins and the control FSMs that react to user input.
- Everything runs in the single `clk` domain. `ms_clk` is sampled as data and is never used as a clock.

Parameters:
- N_BTN, 5, number of independent button channels.
- STABLE_MS, 20, number of consecutive ms ticks an input must differ from the current level before the level flips; legal range 1..31.
- CNT_W, 5, width of each per-channel tick counter; must satisfy 2**CNT_W > STABLE_MS.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ms_clk  in  1  1 kHz 50%-duty square wave from the clock divider, generated in the clk domain.
- btn_raw  in  N_BTN  raw active-high button pins, asynchronous, bouncing.
- btn_level  out  N_BTN  debounced level, registered.
- btn_press  out  N_BTN  one-clk pulse on each debounced 0->1 transition.
- btn_release  out  N_BTN  one-clk pulse on each debounced 1->0 transition.

Behaviour:
- Reset values:
  - btn_level, btn_press, btn_release and all counters are 0.
  - Synchroniser flops are 0.
  - ms_d is 1, which prevents a false tick if ms_clk is high when reset is released.
- Tick generation:
  - ms_d is ms_clk registered.
  - tick = ms_clk & ~ms_d, giving exactly one clk cycle per 1 ms.
  - With ms_clk held constant there are no ticks and no level can change.
- Synchroniser: two flops per btn_raw bit, giving btn_s. Raw-to-btn_s latency is 2 clk.
- Per-channel FSM, two states:
  - STABLE: counter=0, btn_s==btn_level.
  - CHANGING: btn_s!=btn_level.
- Transitions, evaluated every clk:
  - btn_s==btn_level: next state is STABLE and the counter clears in that same cycle regardless of tick. A glitch back to the current level aborts the change.
  - btn_s!=btn_level, tick=0: hold counter.
  - btn_s!=btn_level, tick=1, counter<STABLE_MS-1: counter+1.
  - btn_s!=btn_level, tick=1, counter==STABLE_MS-1: commit.
    - btn_level <= btn_s, counter <= 0, return to STABLE.
    - btn_press <= btn_s, btn_release <= ~btn_s.
- Commit therefore occurs on the STABLE_MS-th tick seen while the input continuously differs from the current level.
- Latency from a clean raw edge to btn_level change is (STABLE_MS-1) ms plus 3..(1 ms + 3) clk cycles.
- Pulses:
  - Registered and asserted in the same cycle btn_level changes.
  - Deasserted the next cycle.
  - Never asserted outside a commit.
- Channels are fully independent. Simultaneous commits on several channels in one cycle are legal and produce simultaneous pulses.
- Counter never exceeds STABLE_MS-1, so there is no wrap-around.
- Reset mid-operation: everything returns to the reset values immediately. A button held through reset produces btn_press STABLE_MS ticks after rst_n rises.
- STABLE_MS=1: commit on the first tick after btn_s differs.

Decomposition:
- Package `btn_pkg` holds:
  - default constants N_BTN_DEF=5, STABLE_MS_DEF=20;
  - the STABLE/CHANGING state encoding;
  - a CNT_W helper function, ceil log2 of STABLE_MS+1.
- Sub-module `debounce_channel` (one bit: synchroniser, counter, FSM, pulse flops) is instantiated N_BTN times by a generate loop.
- The top level holds only the tick generator and the generate loop.

Test Plan:
- Bench drives ms_clk as a square wave with a period of 100 clk cycles (a scaled ms) and sets STABLE_MS=4 unless stated otherwise.
- Reset with btn_raw=5'b00000 -> all outputs 0 and no pulses for 10 ticks. Assert rst_n low while ms_clk=1 -> no tick on release.
- btn_raw[0] 0->1 held clean -> btn_level[0]=1 and btn_press[0] one cycle high on the 4th tick after btn_s changes. Release -> btn_release[0] pulse on the 4th tick. Other bits stay 0.
- Bounce btn_raw[1] toggling every 30 clk for 300 clk, then settle at 1 -> no pulse during the bounce; exactly one btn_press[1] on the 4th tick after settling.
- Glitch btn_raw[2] high for 250 clk (2 ticks), then low -> btn_level[2] stays 0, no pulses, counter returns to 0.
- btn_raw=5'b11111 in one cycle -> all five btn_press bits pulse in the same cycle. Assert rst_n mid-count -> counters clear and no pulse appears until a full 4 ticks after reset release.
- Hold ms_clk=0 for 1000 clk while toggling btn_raw -> no level change. Repeat with STABLE_MS=1 -> commit on the first tick.
